odd_count_sequencer: RTL

Controller that owns and sequences an odd-value counter (1, 3, 5, … up to 2^WIDTH-1). It accepts a start request with an odd target, steps the counter by 2 per clock, and signals completion with a one-cycle done pulse. Pause, abort and a looping mode let higher-level test and control logic drive the counter without touching it directly.

---
 rtl/odd_count_sequencer.sv | 86 ++++++++
 1 files changed

// File: rtl/odd_count_sequencer.sv
// Odd-value counter sequencer: runs 1,3,5,... up to a latched odd target and
// reports each target hit with a done pulse, with pause, abort and loop modes.
//
// state | meaning
// IDLE  | waiting for start; count holds its last value
// RUN   | stepping count by 2 toward target_q (busy=1)
module odd_count_sequencer #(
  parameter int WIDTH = 4,
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             loop,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LAP_W-1:0] laps
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LAP_W-1:0] LAPS_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] target_q;
  logic             loop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      laps     <= '0;
      target_q <= '0;
      loop_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (target[0]) begin
              target_q <= target;
              loop_q   <= loop;
              count    <= WIDTH'(1);
              laps     <= '0;
              busy     <= 1'b1;
              state    <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else if (!pause) begin
            if (count == target_q) begin
              done <= 1'b1;
              if (laps != LAPS_MAX) laps <= laps + LAP_W'(1);
              if (loop_q) begin
                count <= WIDTH'(1);
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              count <= count + WIDTH'(2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
